memory_interface_initiator: RTL and testbench
=============================================

Name: memory_interface_initiator

Overview:
- Synthesizable initiator for the phoeniX memory-interface protocol (enable / state / address / frame_mask / shared 32-bit data bus).
- Accepts single load/store requests from a simple valid/ready client, such as a DMA engine or debug loader, and runs one bus transaction per request.
- Returns aligned, sign- or zero-extended read data with a single-cycle response pulse.
- Sits opposite the memory responder: it drives the bus and the memory answers.

Parameters:
- LATENCY, 0: extra cycles enable is held before read data is captured (0 = one-cycle memory).
- ADDRESS_WIDTH, 32: width of request and bus address.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- reset  input  1  asynchronous, active-high (`ENABLE` = asserted).
- req_valid  input  1  client request present.
- req_ready  output  1  initiator can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word; 11 is illegal.
- req_unsigned  input  1  zero-extend load data (lbu/lhu).
- req_address  input  ADDRESS_WIDTH  byte address.
- req_wdata  input  32  store data, right-aligned.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_error  output  1  request rejected (misaligned or illegal size); qualified by rsp_valid.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- memory_interface_enable  output  1  bus transaction active.
- memory_interface_state  output  1  `READ` / `WRITE`.
- memory_interface_address  output  ADDRESS_WIDTH  full byte address (the responder word-indexes it).
- memory_interface_frame_mask  output  4  byte-lane enables; mask[3] = bits 7:0 ... mask[0] = bits 31:24.
- memory_interface_data  inout  32  driven only during a write access, otherwise high-Z.

Behaviour:
- Reset values: req_ready 0 while reset is asserted, then 1; rsp_valid 0; rsp_error 0; rsp_rdata 0; enable `DISABLE`; state `READ`; address 0; frame_mask 0; data bus high-Z; FSM IDLE; latency counter 0.
- FSM has three states: IDLE, ACCESS, RESPOND.
  - req_ready = (state == IDLE).
  - Handshake is req_valid && req_ready, sampled at posedge.
- IDLE:
  - On handshake, latch write, size, unsigned, address, wdata and offset = address[1:0].
  - Illegal request (size 11, half at an odd address, word with offset != 0): go to RESPOND with error=1 and issue no bus transaction.
  - Otherwise: go to ACCESS, load counter = LATENCY, and assert enable from the next cycle.
- ACCESS:
  - enable is high.
  - frame_mask by size and offset:
    - byte: one lane, mask bit (3 - offset).
    - half at offset 0: 1100.
    - half at offset 2: 0011.
    - word: 1111.
  - Writes: bus carries wdata shifted left by 8*offset bits. Reads: bus is high-Z.
  - Counter decrements each cycle; at the posedge where counter == 0:
    - for reads, capture the bus into a data register;
    - drop enable;
    - go to RESPOND.
  - With LATENCY = 0, enable is high for exactly one cycle.
- RESPOND:
  - rsp_valid = 1 for exactly one cycle, then IDLE.
  - rsp_rdata = captured word >> 8*offset, truncated to size, then sign- or zero-extended.
- Latency: request accepted at edge N → rsp_valid high in cycle N+2+LATENCY. The next request can be accepted at edge N+3+LATENCY (no back-to-back overlap).
- The response has no backpressure; the client must always accept rsp_valid.
- Reset asserted mid-ACCESS: enable and frame_mask drop immediately (async), bus released, FSM to IDLE, no response issued, latched request discarded.
- req_valid while not ready: ignored and not latched; the client holds its request.
- X/Z captured on a read propagates unmodified; no checking is done.

Decomposition:
- Shared constants header (existing): `ENABLE`, `DISABLE`, `READ`, `WRITE`.
- Add size codes BYTE/HALF/WORD and the FSM state encodings to the same header.
- One sub-module is natural: memory_interface_lane_aligner.
  - Combinational.
  - Inputs: size, offset, unsigned, raw word.
  - Outputs: frame_mask, shifted write data, extended read data.
  - Shared with the load/store path.

Test Plan:
- Word load: memory[0x40] = 0xDEADBEEF, LATENCY=0, lw 0x100 → enable high for 1 cycle, mask 1111, rsp_rdata 0xDEADBEEF at N+2, error 0.
- Signed and unsigned byte load: word at 0x200 = 0x80FF0000.
  - lb 0x203 → mask 0001, rsp 0xFFFFFF80.
  - lbu 0x203 → rsp 0x00000080.
  - lb 0x202 → mask 0010, rsp 0xFFFFFFFF.
- Half store: sh 0x1234 to 0x102 → mask 0011, bus 0x12340000 during enable, high-Z afterwards; memory[0x40] upper half becomes 0x1234, lower half unchanged; rsp_rdata 0.
- Misaligned: lw 0x101 and a request with size 11 → enable never asserted, rsp_valid at N+1 with rsp_error 1 and rsp_rdata 0.
- LATENCY=3 read → enable high for 4 cycles, rsp_valid at N+5, req_ready low throughout; a req_valid held during the access is accepted only after RESPOND.
- Reset during ACCESS → enable 0 and bus high-Z in the same cycle, no rsp_valid; after release, a new lw 0x100 completes normally.

Source files
------------

// File: rtl/memory_interface_initiator_pkg.sv
// Shared constants for the phoeniX memory-interface initiator: bus encodings,
// access-size codes, FSM state encoding and the request legality rule.
package memory_interface_initiator_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;
  localparam logic READ    = 1'b0;
  localparam logic WRITE   = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ACCESS  = 2'b01,
    ST_RESPOND = 2'b10
  } state_e;

  // A request is rejected before touching the bus when its size is the
  // reserved code or it straddles its natural alignment.
  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = offset[0];
      SIZE_WORD: bad = (offset != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/memory_interface_lane_aligner.sv
// Combinational byte-lane steering: frame mask, write-data placement and
// read-data extraction with sign/zero extension.
module memory_interface_lane_aligner
  import memory_interface_initiator_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  frame_mask,
  output logic [31:0] wdata_shifted,
  output logic [31:0] rdata_ext
);

  logic [4:0]  shift;
  logic [31:0] rdata_shifted;

  always_comb begin
    shift         = {offset, 3'b000};
    wdata_shifted = wdata << shift;
    rdata_shifted = rdata >> shift;
    frame_mask    = 4'b0000;
    rdata_ext     = 32'h0;
    // mask[3] covers bits 7:0, so lane order is reversed relative to offset
    case (size)
      SIZE_BYTE: begin
        frame_mask = 4'b1000 >> offset;
        rdata_ext  = is_unsigned ? {24'h0, rdata_shifted[7:0]}
                                 : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      end
      SIZE_HALF: begin
        frame_mask = offset[1] ? 4'b0011 : 4'b1100;
        rdata_ext  = is_unsigned ? {16'h0, rdata_shifted[15:0]}
                                 : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      end
      SIZE_WORD: begin
        frame_mask = 4'b1111;
        rdata_ext  = rdata_shifted;
      end
      default: begin
        frame_mask = 4'b0000;
        rdata_ext  = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/memory_interface_initiator.sv
// phoeniX memory-interface initiator: turns one valid/ready load/store request
// into one bus transaction and returns a single-cycle response pulse.
module memory_interface_initiator
  import memory_interface_initiator_pkg::*;
#(
  parameter int LATENCY       = 0,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  input  logic [31:0]              req_wdata,
  output logic                     rsp_valid,
  output logic                     rsp_error,
  output logic [31:0]              rsp_rdata,
  output logic                     memory_interface_enable,
  output logic                     memory_interface_state,
  output logic [ADDRESS_WIDTH-1:0] memory_interface_address,
  output logic [3:0]               memory_interface_frame_mask,
  inout  wire  [31:0]              memory_interface_data
);

  localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  // Handshake: a request transfers on a posedge where req_valid && req_ready;
  // the client holds its request until then. Responses have no backpressure.
  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         count_q;
  logic                     write_q;
  logic [1:0]               size_q;
  logic                     unsigned_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [31:0]              wdata_q;
  logic [31:0]              rdata_q;
  logic                     err_q;

  logic [3:0]  lane_mask;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;
  logic        handshake;
  logic        req_bad;

  assign req_ready = (state_q == ST_IDLE) && !reset;
  assign handshake = req_valid && req_ready;
  assign req_bad   = is_illegal(req_size, req_address[1:0]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (handshake) state_d = req_bad ? ST_RESPOND : ST_ACCESS;
      ST_ACCESS:  if (count_q == '0) state_d = ST_RESPOND;
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      write_q    <= 1'b0;
      size_q     <= SIZE_BYTE;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (handshake) begin
            write_q    <= req_write;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            addr_q     <= req_address;
            wdata_q    <= req_wdata;
            err_q      <= req_bad;
            count_q    <= CNT_W'(LATENCY);
          end
        end
        ST_ACCESS: begin
          if (count_q != '0) begin
            count_q <= count_q - 1'b1;
          end else if (!write_q) begin
            rdata_q <= memory_interface_data;
          end
        end
        default: ;
      endcase
    end
  end

  memory_interface_lane_aligner u_lane_aligner (
    .size          (size_q),
    .offset        (addr_q[1:0]),
    .is_unsigned   (unsigned_q),
    .wdata         (wdata_q),
    .rdata         (rdata_q),
    .frame_mask    (lane_mask),
    .wdata_shifted (lane_wdata),
    .rdata_ext     (lane_rdata)
  );

  // Bus outputs decode straight from the state register so an async reset
  // releases the bus in the same cycle.
  assign memory_interface_enable     = (state_q == ST_ACCESS) ? ENABLE : DISABLE;
  assign memory_interface_state      = ((state_q == ST_ACCESS) && write_q) ? WRITE : READ;
  assign memory_interface_address    = addr_q;
  assign memory_interface_frame_mask = (state_q == ST_ACCESS) ? lane_mask : 4'b0000;
  assign memory_interface_data       = ((state_q == ST_ACCESS) && write_q) ? lane_wdata : 32'hzzzz_zzzz;

  assign rsp_valid = (state_q == ST_RESPOND);
  assign rsp_error = (state_q == ST_RESPOND) && err_q;
  assign rsp_rdata = ((state_q == ST_RESPOND) && !err_q && !write_q) ? lane_rdata : 32'h0;

endmodule

// File: tb/tb_memory_interface_initiator.sv
// Directed bench: a LATENCY=0 and a LATENCY=3 initiator share one memory
// model; hand-computed loads, stores, errors, latency and reset cases.
module tb_memory_interface_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        rv0, rv1;
  logic        rw;
  logic [1:0]  rs;
  logic        ru;
  logic [31:0] ra, rwd;

  logic        rr0, rsv0, rse0, en0, st0;
  logic [31:0] rsd0, ad0;
  logic [3:0]  fm0;
  wire  [31:0] bus0;

  logic        rr1, rsv1, rse1, en1, st1;
  logic [31:0] rsd1, ad1;
  logic [3:0]  fm1;
  wire  [31:0] bus1;

  logic [31:0] mem [0:255];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  memory_interface_initiator #(.LATENCY(0), .ADDRESS_WIDTH(32)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(rv0), .req_ready(rr0), .req_write(rw), .req_size(rs),
    .req_unsigned(ru), .req_address(ra), .req_wdata(rwd),
    .rsp_valid(rsv0), .rsp_error(rse0), .rsp_rdata(rsd0),
    .memory_interface_enable(en0), .memory_interface_state(st0),
    .memory_interface_address(ad0), .memory_interface_frame_mask(fm0),
    .memory_interface_data(bus0)
  );

  memory_interface_initiator #(.LATENCY(3), .ADDRESS_WIDTH(32)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(rv1), .req_ready(rr1), .req_write(rw), .req_size(rs),
    .req_unsigned(ru), .req_address(ra), .req_wdata(rwd),
    .rsp_valid(rsv1), .rsp_error(rse1), .rsp_rdata(rsd1),
    .memory_interface_enable(en1), .memory_interface_state(st1),
    .memory_interface_address(ad1), .memory_interface_frame_mask(fm1),
    .memory_interface_data(bus1)
  );

  // Responder model: drives read data while enabled, writes masked lanes.
  assign bus0 = (en0 && !st0) ? mem[ad0[9:2]] : 32'hzzzz_zzzz;
  assign bus1 = (en1 && !st1) ? mem[ad1[9:2]] : 32'hzzzz_zzzz;

  always @(posedge clk) begin
    if (en0 && st0) begin
      if (fm0[3]) mem[ad0[9:2]][7:0]   <= bus0[7:0];
      if (fm0[2]) mem[ad0[9:2]][15:8]  <= bus0[15:8];
      if (fm0[1]) mem[ad0[9:2]][23:16] <= bus0[23:16];
      if (fm0[0]) mem[ad0[9:2]][31:24] <= bus0[31:24];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic bus_released(input logic [31:0] v);
    return (v === 32'hzzzz_zzzz) || (v === 32'h0);
  endfunction

  // One request on the LATENCY=0 initiator, watched cycle by cycle after the accepting edge.
  task automatic txn0(input string tag, input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] wd, input logic exp_err,
                      input logic [31:0] exp_rdata, input logic [3:0] exp_mask,
                      input logic [31:0] exp_bus);
    int en_cnt;
    int rsp_k;
    logic [3:0]  mask_seen;
    logic [31:0] bus_seen;
    @(negedge clk);
    rw = w; rs = sz; ru = u; ra = a; rwd = wd; rv0 = 1'b1;
    check({tag, ":ready"}, {31'h0, rr0}, 32'h1);
    @(posedge clk);
    #1 rv0 = 1'b0;
    en_cnt = 0; rsp_k = 0; mask_seen = 4'h0; bus_seen = 32'h0;
    for (int k = 1; k <= 8 && rsp_k == 0; k++) begin
      @(negedge clk);
      if (en0) begin
        en_cnt++;
        mask_seen = fm0;
        bus_seen  = bus0;
      end
      if (rsv0) begin
        rsp_k = k;
        check({tag, ":rdata"}, rsd0, exp_rdata);
        check({tag, ":error"}, {31'h0, rse0}, {31'h0, exp_err});
      end
    end
    check({tag, ":enable_cycles"}, en_cnt, exp_err ? 32'd0 : 32'd1);
    check({tag, ":rsp_cycle"}, rsp_k, exp_err ? 32'd1 : 32'd2);
    if (!exp_err) check({tag, ":mask"}, {28'h0, mask_seen}, {28'h0, exp_mask});
    if (w && !exp_err) check({tag, ":bus"}, bus_seen, exp_bus);
    @(negedge clk);
    check({tag, ":single_pulse"}, {31'h0, rsv0}, 32'h0);
    check({tag, ":idle_ready"}, {31'h0, rr0}, 32'h1);
    check({tag, ":bus_released"}, {31'h0, bus_released(bus0)}, 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int en_a, first_ready, rsp1_k, rsp2_k, pulses;
    logic [31:0] rdata_a, rdata_b;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'hDEAD_BEEF;
    mem[8'h80] = 32'h80FF_0000;
    reset = 1'b1; rv0 = 1'b0; rv1 = 1'b0;
    rw = 1'b0; rs = 2'b00; ru = 1'b0; ra = 32'h0; rwd = 32'h0;

    // Reset values
    #12;
    check("rst:ready", {31'h0, rr0}, 32'h0);
    check("rst:rsp_valid", {31'h0, rsv0}, 32'h0);
    check("rst:rsp_error", {31'h0, rse0}, 32'h0);
    check("rst:rsp_rdata", rsd0, 32'h0);
    check("rst:enable", {31'h0, en0}, 32'h0);
    check("rst:state", {31'h0, st0}, 32'h0);
    check("rst:address", ad0, 32'h0);
    check("rst:mask", {28'h0, fm0}, 32'h0);
    check("rst:bus", {31'h0, bus_released(bus0)}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    #1 check("post_rst:ready", {31'h0, rr0}, 32'h1);

    // Loads, store and rejected requests
    txn0("lw_100",  1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, 32'hDEAD_BEEF, 4'b1111, 32'h0);
    txn0("lb_203",  1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 1'b0, 32'hFFFF_FF80, 4'b0001, 32'h0);
    txn0("lbu_203", 1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 1'b0, 32'h0000_0080, 4'b0001, 32'h0);
    txn0("lb_202",  1'b0, 2'b00, 1'b0, 32'h202, 32'h0, 1'b0, 32'hFFFF_FFFF, 4'b0010, 32'h0);
    txn0("lhu_200", 1'b0, 2'b01, 1'b1, 32'h200, 32'h0, 1'b0, 32'h0000_0000, 4'b1100, 32'h0);
    txn0("sh_102",  1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_1234, 1'b0, 32'h0, 4'b0011, 32'h1234_0000);
    check("sh_102:memory", mem[8'h40], 32'h1234_BEEF);
    txn0("lw_101",  1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0);
    txn0("size_11", 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0);
    txn0("sh_101",  1'b1, 2'b01, 1'b0, 32'h101, 32'h0000_5678, 1'b1, 32'h0, 4'b0000, 32'h0);
    check("sh_101:memory", mem[8'h40], 32'h1234_BEEF);

    // LATENCY=3: lw 0x200, then lbu 0x203 held valid throughout the first access
    @(negedge clk);
    rw = 1'b0; rs = 2'b10; ru = 1'b0; ra = 32'h200; rv1 = 1'b1;
    check("lat3:ready", {31'h0, rr1}, 32'h1);
    @(posedge clk);
    #1 ra = 32'h203; rs = 2'b00; ru = 1'b1;
    en_a = 0; first_ready = 0; rsp1_k = 0; rsp2_k = 0; rdata_a = 32'h0; rdata_b = 32'h0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (en1 && first_ready == 0) en_a++;
      if (rsv1) begin
        if (rsp1_k == 0) begin rsp1_k = k; rdata_a = rsd1; end
        else begin rsp2_k = k; rdata_b = rsd1; end
      end
      if (rr1 && first_ready == 0) begin
        first_ready = k;
        @(posedge clk);
        #1 rv1 = 1'b0;
      end
    end
    rv1 = 1'b0;
    check("lat3:enable_cycles", en_a, 32'd4);
    check("lat3:rsp_cycle", rsp1_k, 32'd5);
    check("lat3:rdata", rdata_a, 32'h80FF_0000);
    check("lat3:ready_return", first_ready, 32'd6);
    check("lat3:held_rsp_cycle", rsp2_k, 32'd11);
    check("lat3:held_rdata", rdata_b, 32'h0000_0080);

    // Reset asserted during ACCESS
    @(negedge clk);
    rw = 1'b0; rs = 2'b10; ru = 1'b0; ra = 32'h100; rv0 = 1'b1;
    @(posedge clk);
    #1 rv0 = 1'b0;
    check("rst_mid:enable_before", {31'h0, en0}, 32'h1);
    reset = 1'b1;
    #1;
    check("rst_mid:enable", {31'h0, en0}, 32'h0);
    check("rst_mid:mask", {28'h0, fm0}, 32'h0);
    check("rst_mid:bus", {31'h0, bus_released(bus0)}, 32'h1);
    @(negedge clk);
    check("rst_mid:ready", {31'h0, rr0}, 32'h0);
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsv0) pulses++;
    end
    check("rst_mid:no_response", pulses, 32'd0);
    txn0("lw_100_after_rst", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, 32'h1234_BEEF, 4'b1111, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
